// File: rtl/aes_pkg.sv
// AES-128 helpers: forward S-box, xtime, round constants and per-round transforms.
// Latency: none, every function here is pure combinational logic.
// Backpressure: not applicable, no flow control lives in this package.
package aes_pkg;

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of the block sits at [127-8i -: 8]; state cell (row r, col c) is byte r+4c.
  function automatic logic [127:0] sub_bytes(input logic [127:0] b);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(b[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] b);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = b[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] b);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[127-32*c -: 8];
      a1 = b[119-32*c -: 8];
      a2 = b[111-32*c -: 8];
      a3 = b[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One AES round plus its key-expansion step, both results registered.
// Latency: 1 cycle from data_in/key_in to data_out/key_out.
// Backpressure: none, a new block is accepted every cycle.
module aes_round
  import aes_pkg::*;
#(
  parameter logic [7:0] RCON  = 8'h01,
  parameter bit         FINAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] data_out,
  output logic [127:0] key_out
);

  logic [31:0]  w0, w1, w2, w3, t;
  logic [127:0] key_next;
  logic [127:0] shifted;
  logic [127:0] mixed;

  // Next round key; runs beside the data path so the S-box is the only deep element.
  always_comb begin
    t        = sub_word(rot_word(key_in[31:0])) ^ {RCON, 24'h000000};
    w0       = key_in[127:96] ^ t;
    w1       = key_in[95:64] ^ w0;
    w2       = key_in[63:32] ^ w1;
    w3       = key_in[31:0] ^ w2;
    key_next = {w0, w1, w2, w3};
  end

  // Round transform; the last round skips MixColumns.
  always_comb begin
    shifted = shift_rows(sub_bytes(data_in));
    mixed   = FINAL ? shifted : mix_columns(shifted);
  end

  // Stage register for this round's data and key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      key_out  <= '0;
    end else begin
      data_out <= mixed ^ key_next;
      key_out  <= key_next;
    end
  end

endmodule

// File: rtl/aes_128_encryptor.sv
// Fully pipelined AES-128 encryptor, one independent block/key pair per cycle.
// Latency: 10 cycles from the capture edge to cipher.
// Backpressure: none, downstream samples cipher at the fixed latency.
module aes_128_encryptor
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] cipher
);

  // Index 0 is the initial AddRoundKey stage, index r the output of round r.
  logic [127:0] data_q [0:10];
  logic [127:0] key_q  [0:10];

  // Stage 0: initial AddRoundKey and round key K0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      key_q[0]  <= '0;
    end else begin
      data_q[0] <= state ^ key;
      key_q[0]  <= key;
    end
  end

  for (genvar r = 1; r <= 10; r++) begin : g_round
    aes_round #(
      .RCON  (RCON[r]),
      .FINAL (r == 10)
    ) u_round (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_q[r-1]),
      .key_in   (key_q[r-1]),
      .data_out (data_q[r]),
      .key_out  (key_q[r])
    );
  end

  assign cipher = data_q[10];

endmodule

// File: tb/tb_aes_128_encryptor.sv
// Bench for aes_128_encryptor: known-answer table, random stream against an
// independent AES model (S-box derived from GF inverse + affine map), hold and reset cases.
module tb_aes_128_encryptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] cipher;

  always #5 clk = ~clk;

  aes_128_encryptor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .state  (state),
    .key    (key),
    .cipher (cipher)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [127:0] val;
    int           due;
    string        name;
  } exp_t;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  exp_t       sb[$];
  exp_t       cur;
  vec_t       vecs[3];
  logic [7:0] sbm[256];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cipher=%h expected=%h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Scoreboard consumer: compares the oldest expected block when its cycle arrives.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sb.size() > 0) begin
      if (sb[0].due == edge_cnt) begin
        cur = sb.pop_front();
        chk(cur.name, cipher, cur.val);
      end else if (sb[0].due < edge_cnt) begin
        cur = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: result never compared, due edge %0d now %0d", cur.name, cur.due, edge_cnt);
      end
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] r;
    for (int x = 0; x < 256; x++) begin
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, 8'(x));
      sbm[x] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbm[tmp[23:16]], sbm[tmp[15:8]], sbm[tmp[7:0]], sbm[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbm[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Drive one block after a falling edge; it is captured at the next rising edge.
  task automatic apply(input logic [127:0] k, input logic [127:0] p,
                       input logic [127:0] e, input string nm);
    @(negedge clk);
    key   = k;
    state = p;
    sb.push_back('{val: e, due: edge_cnt + 11, name: nm});
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain(input string nm, input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d results still pending", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, p;
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, pt: 128'h3243f6a8885a308d313198a2e0370734,
                ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f, pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n = 1'b0;
    key   = '0;
    state = '0;
    build_sbox();
    #1 chk("reset_state", cipher, 128'h0);
    repeat (3) @(negedge clk);
    chk("reset_held", cipher, 128'h0);
    rst_n = 1'b1;

    // Known answers on consecutive edges with the key changing every cycle.
    for (int i = 0; i < 3; i++) apply(vecs[i].key, vecs[i].pt, vecs[i].ct, $sformatf("kat%0d", i));

    // Random stream against the model, with one fixed low-entropy vector mixed in.
    for (int n = 0; n < 1000; n++) begin
      k = rand128();
      p = rand128();
      if (n == 500) begin
        k = 128'h0;
        p = 128'h00000101030307070f0f1f1f3f3f7f7f;
      end
      apply(k, p, aes_model(k, p), (n == 500) ? "rand_fixed" : "rand");
    end

    // Hold the same inputs for 20 cycles.
    for (int i = 0; i < 20; i++) apply(vecs[0].key, vecs[0].pt, vecs[0].ct, "hold");
    drain("hold_drain", 30);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("hold_after_edge", cipher, vecs[0].ct);
      @(negedge clk);
      chk("hold_mid_cycle", cipher, vecs[0].ct);
    end

    // Reset asserted between edges while blocks are in flight.
    for (int i = 0; i < 6; i++) begin
      k = rand128();
      p = rand128();
      apply(k, p, aes_model(k, p), "pre_reset");
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 chk("reset_async", cipher, 128'h0);
    @(negedge clk);
    chk("reset_mid_hold", cipher, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    key   = vecs[0].key;
    state = vecs[0].pt;
    sb.push_back('{val: vecs[0].ct, due: edge_cnt + 11, name: "post_reset_kat"});
    for (int i = 0; i < 5; i++) begin
      k = rand128();
      p = rand128();
      apply(k, p, aes_model(k, p), "post_reset_rand");
    end
    drain("final_drain", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
